spi_reg_slave: RTL

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_pkg.sv | 32 +++
 rtl/spi_sync.sv | 30 +++
 rtl/spi_reg_slave.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants, command-byte layout and FSM state type for the SPI register slave.
package spi_reg_pkg;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 8;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 3;
    localparam int CMD_ADDR_LSB = 0;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic state_t cmd_next_state(input logic [DATA_W-1:0] cmd);
        state_t nxt;
        nxt = ST_WR_DATA;
        unique case (cmd[CMD_RW_BIT])
            RW_WRITE: nxt = ST_WR_DATA;
            RW_READ:  nxt = ST_RD_DATA;
            default:  nxt = ST_WR_DATA;
        endcase
        return nxt;
    endfunction
endpackage

// File: rtl/spi_sync.sv
// Multi-stage single-bit synchronizer with a configurable depth and reset level.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= RESET_VAL;
                    else     sync_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= RESET_VAL;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave exposing 16 byte registers, oversampled on clk.
// Optional build macro SPI_REG_SLAVE_AUTOINC_EN: data bytes auto-increment the address.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] REG_RESET   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);
    localparam logic [7:0] SETTLE = 8'(SYNC_STAGES);

    logic sclk_s, mosi_s, ss_n_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_n_s));

    logic       sclk_prev_reg, ss_prev_reg;
    logic [7:0] settle_cnt_reg;
    logic       armed_reg;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign ss_fall   = ~ss_n_s & ss_prev_reg;
    assign ss_rise   = ss_n_s & ~ss_prev_reg;

    // The ss_n chain resets high, so a select held low across reset would look like a
    // fresh falling edge; only arm once a genuine high level has passed through the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_reg  <= 1'b0;
            ss_prev_reg    <= 1'b1;
            settle_cnt_reg <= 8'd0;
            armed_reg      <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_n_s;
            if (settle_cnt_reg < SETTLE)
                settle_cnt_reg <= settle_cnt_reg + 8'd1;
            armed_reg <= armed_reg | ((settle_cnt_reg >= SETTLE) & ss_n_s);
        end
    end

    state_t            state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [6:0]        rx_shift_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic              miso_reg;
    logic              wr_strobe_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] host_rd_data_reg;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              in_xfer, byte_done, reg_we;
    logic [DATA_W-1:0] rx_byte;
    logic [ADDR_W-1:0] cmd_addr;

    assign in_xfer   = (state_reg == ST_CMD) || (state_reg == ST_WR_DATA) ||
                       (state_reg == ST_RD_DATA);
    assign byte_done = in_xfer && sclk_rise && (bit_cnt_reg == 3'd7);
    assign rx_byte   = {rx_shift_reg, mosi_s};
    assign cmd_addr  = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign reg_we    = byte_done && (state_reg == ST_WR_DATA);

`ifdef SPI_REG_SLAVE_AUTOINC_EN
    logic [ADDR_W-1:0] next_addr;
    assign next_addr = addr_reg + ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= 7'd0;
            addr_reg      <= '0;
            tx_shift_reg  <= '0;
            miso_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (in_xfer && sclk_rise) begin
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                rx_shift_reg <= rx_byte[6:0];
            end
            case (state_reg)
                ST_IDLE: begin
                    miso_reg    <= 1'b0;
                    bit_cnt_reg <= 3'd0;
                    if (ss_fall && armed_reg)
                        state_reg <= ST_CMD;
                end
                ST_CMD: begin
                    if (byte_done) begin
                        addr_reg  <= cmd_addr;
                        state_reg <= cmd_next_state(rx_byte);
                        if (cmd_next_state(rx_byte) == ST_RD_DATA)
                            tx_shift_reg <= regs[cmd_addr];
                    end
                end
                ST_WR_DATA: begin
                    if (byte_done) begin
                        wr_strobe_reg <= 1'b1;
                        wr_addr_reg   <= addr_reg;
                        wr_data_reg   <= rx_byte;
`ifdef SPI_REG_SLAVE_AUTOINC_EN
                        addr_reg <= next_addr;
`else
                        state_reg <= ST_DONE;
`endif
                    end
                end
                ST_RD_DATA: begin
                    if (sclk_fall) begin
                        miso_reg     <= tx_shift_reg[DATA_W-1];
                        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                    end
                    if (byte_done) begin
`ifdef SPI_REG_SLAVE_AUTOINC_EN
                        addr_reg     <= next_addr;
                        tx_shift_reg <= regs[next_addr];
`else
                        state_reg <= ST_DONE;
                        miso_reg  <= 1'b0;
`endif
                    end
                end
                ST_DONE: miso_reg <= 1'b0;
                default: state_reg <= ST_IDLE;
            endcase
            // Deselect wins over everything except a byte that completed this same cycle.
            if (ss_rise) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 3'd0;
                miso_reg    <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst)
                    regs[gi] <= REG_RESET;
                else if (reg_we && (addr_reg == ADDR_W'(gi)))
                    regs[gi] <= rx_byte;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) host_rd_data_reg <= REG_RESET;
        else     host_rd_data_reg <= regs[host_addr];
    end

    assign miso         = miso_reg;
    assign host_rd_data = host_rd_data_reg;
    assign wr_strobe    = wr_strobe_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign busy         = ~ss_n_s;
endmodule
